// File: rtl/pc_seq_pkg.sv
// Shared types and sizing helpers for the pc_seq program counter / sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {JM_REL, JM_ABS, JM_CALL, JM_RET} jump_mode_e;

  typedef enum logic {StRun, StHalted} seq_state_e;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int unsigned ras_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index into a depth-entry array (at least one bit).
  function automatic int unsigned ras_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Decoder <-> sequencer control bundle: branch controls, halt table, PC and status.
interface pc_seq_if #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned OFF_W     = 8,
  parameter int unsigned NUM_HALT  = 3,
  parameter int unsigned RAS_DEPTH = 4
);
  import pc_seq_pkg::*;

  localparam int unsigned CNT_W = ras_cnt_w(RAS_DEPTH);

  logic                     Stall;
  logic                     BranchEnable;
  logic                     BranchTaken;
  jump_mode_e               JumpMode;
  logic                     JumpDirection;
  logic [OFF_W-1:0]         JumpAmount;
  logic [PC_W-1:0]          JumpTarget;
  logic [NUM_HALT*PC_W-1:0] HaltAddrs;
  logic [NUM_HALT-1:0]      HaltMask;
  logic                     Resume;
  logic [PC_W-1:0]          PC;
  logic                     halt;
  logic                     StackErr;
  logic [CNT_W-1:0]         StackDepth;

  modport master (
    output Stall, BranchEnable, BranchTaken, JumpMode, JumpDirection, JumpAmount,
           JumpTarget, HaltAddrs, HaltMask, Resume,
    input  PC, halt, StackErr, StackDepth
  );

  modport slave (
    input  Stall, BranchEnable, BranchTaken, JumpMode, JumpDirection, JumpAmount,
           JumpTarget, HaltAddrs, HaltMask, Resume,
    output PC, halt, StackErr, StackDepth
  );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack: small LIFO with an async-reset occupancy counter.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10,
  localparam int unsigned CNT_W = ras_cnt_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             init,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] depth
);

  localparam int unsigned IDX_W = ras_idx_w(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = IDX_W'(cnt_q);
  assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));
  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign top    = mem_q[rd_idx];
  assign depth  = cnt_q;

  always_ff @(posedge CLK or posedge init) begin
    if (init) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge CLK) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program counter / sequencer: relative and absolute jumps, call/return via pc_ras,
// programmable halt-address table, stall and resume.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned OFF_W     = 8,
  parameter int unsigned NUM_HALT  = 3,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input logic     CLK,
  input logic     init,
  pc_seq_if.slave bus
);

  localparam int unsigned CNT_W = ras_cnt_w(RAS_DEPTH);

  seq_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              err_q, err_d;
  logic              halt_hit;
  logic              push, pop;
  logic [PC_W-1:0]   ras_top;
  logic              ras_full, ras_empty;
  logic [CNT_W-1:0]  ras_depth;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   off_ext;
  logic [PC_W+OFF_W-1:0] off_wide;

  assign pc_inc   = pc_q + PC_W'(1);
  assign off_wide = {{PC_W{1'b0}}, bus.JumpAmount};
  assign off_ext  = off_wide[PC_W-1:0];

  always_comb begin
    halt_hit = 1'b0;
    for (int i = 0; i < NUM_HALT; i++) begin
      if (bus.HaltMask[i] && (bus.HaltAddrs[i*PC_W +: PC_W] == pc_q)) halt_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!bus.Stall) begin
          if (halt_hit) begin
            // Step past the halt address so Resume does not re-trigger it.
            pc_d    = pc_inc;
            state_d = StHalted;
          end else if (bus.BranchEnable && bus.BranchTaken) begin
            unique case (bus.JumpMode)
              JM_REL: pc_d = bus.JumpDirection ? pc_q + off_ext : pc_q - off_ext;
              JM_ABS: pc_d = bus.JumpTarget;
              JM_CALL: begin
                if (!ras_full) begin
                  push = 1'b1;
                  pc_d = bus.JumpTarget;
                end else begin
                  err_d   = 1'b1;
                  state_d = StHalted;
                end
              end
              JM_RET: begin
                if (!ras_empty) begin
                  pop  = 1'b1;
                  pc_d = ras_top;
                end else begin
                  err_d   = 1'b1;
                  state_d = StHalted;
                end
              end
              default: pc_d = pc_inc;
            endcase
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      StHalted: begin
        if (bus.Resume) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK or posedge init) begin
    if (init) begin
      state_q <= StRun;
      pc_q    <= PC_W'(RESET_PC);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .CLK       (CLK),
    .init      (init),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .depth     (ras_depth)
  );

  assign bus.PC         = pc_q;
  assign bus.halt       = (state_q == StHalted);
  assign bus.StackErr   = err_q;
  assign bus.StackDepth = ras_depth;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: sequencing, relative wrap, call/return, RAS errors, halt, stall.
module tb_pc_seq;
  import pc_seq_pkg::*;

  logic CLK = 1'b0;
  logic init;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 CLK = ~CLK;

  pc_seq_if #(.PC_W(10), .OFF_W(8), .NUM_HALT(3), .RAS_DEPTH(4)) bus ();

  pc_seq #(
    .PC_W      (10),
    .OFF_W     (8),
    .NUM_HALT  (3),
    .RAS_DEPTH (4),
    .RESET_PC  (0)
  ) dut (
    .CLK  (CLK),
    .init (init),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle();
    bus.Stall         = 1'b0;
    bus.BranchEnable  = 1'b0;
    bus.BranchTaken   = 1'b0;
    bus.JumpMode      = JM_REL;
    bus.JumpDirection = 1'b0;
    bus.JumpAmount    = '0;
    bus.JumpTarget    = '0;
    bus.Resume        = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    bus.HaltAddrs = '0;
    bus.HaltMask  = '0;
    init = 1'b1;
    #2;
    init = 1'b0;
  endtask

  task automatic branch(input jump_mode_e mode, input logic dir, input int unsigned amt,
                        input int unsigned tgt);
    bus.BranchEnable  = 1'b1;
    bus.BranchTaken   = 1'b1;
    bus.JumpMode      = mode;
    bus.JumpDirection = dir;
    bus.JumpAmount    = 8'(amt);
    bus.JumpTarget    = 10'(tgt);
    step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: reset, sequential advance, relative jumps
    do_reset();
    check("rst_pc", bus.PC, 0);
    check("rst_halt", bus.halt, 0);
    check("rst_err", bus.StackErr, 0);
    check("rst_depth", bus.StackDepth, 0);
    step(5);
    check("seq5", bus.PC, 5);
    branch(JM_REL, 1'b1, 20, 0);
    check("rel_fwd", bus.PC, 25);
    branch(JM_REL, 1'b0, 10, 0);
    check("rel_back", bus.PC, 15);

    // 2: halt table, hold while halted, resume
    do_reset();
    bus.HaltAddrs[0 +: 10] = 10'd30;
    bus.HaltMask = 3'b001;
    for (int i = 0; i < 40 && !bus.halt; i++) step();
    check("halt_pc", bus.PC, 31);
    check("halt_set", bus.halt, 1);
    step(4);
    check("halt_hold_pc", bus.PC, 31);
    check("halt_hold", bus.halt, 1);
    bus.Resume = 1'b1;
    step();
    bus.Resume = 1'b0;
    check("resume_halt", bus.halt, 0);
    check("resume_pc", bus.PC, 31);
    step();
    check("resume_next", bus.PC, 32);

    // 3: call and return
    do_reset();
    branch(JM_ABS, 1'b0, 0, 7);
    check("abs", bus.PC, 7);
    branch(JM_CALL, 1'b0, 0, 100);
    check("call_pc", bus.PC, 100);
    check("call_depth", bus.StackDepth, 1);
    step(4);
    branch(JM_RET, 1'b0, 0, 0);
    check("ret_pc", bus.PC, 8);
    check("ret_depth", bus.StackDepth, 0);

    // 3b: nested LIFO order
    do_reset();
    branch(JM_CALL, 1'b0, 0, 50);
    branch(JM_CALL, 1'b0, 0, 60);
    branch(JM_RET, 1'b0, 0, 0);
    check("lifo_ret1", bus.PC, 51);
    branch(JM_RET, 1'b0, 0, 0);
    check("lifo_ret2", bus.PC, 1);
    check("lifo_err", bus.StackErr, 0);

    // 4: overflow on fifth call
    do_reset();
    for (int i = 0; i < 4; i++) branch(JM_CALL, 1'b0, 0, 200);
    check("full_depth", bus.StackDepth, 4);
    check("full_err", bus.StackErr, 0);
    branch(JM_CALL, 1'b0, 0, 300);
    check("ovf_pc", bus.PC, 200);
    check("ovf_err", bus.StackErr, 1);
    check("ovf_halt", bus.halt, 1);
    check("ovf_depth", bus.StackDepth, 4);
    bus.Resume = 1'b1;
    step();
    bus.Resume = 1'b0;
    check("ovf_err_sticky", bus.StackErr, 1);

    // 4b: underflow, then async reset clears sticky error
    do_reset();
    branch(JM_RET, 1'b0, 0, 0);
    check("udf_pc", bus.PC, 0);
    check("udf_err", bus.StackErr, 1);
    check("udf_halt", bus.halt, 1);
    init = 1'b1;
    #1;
    check("async_err", bus.StackErr, 0);
    check("async_halt0", bus.halt, 0);
    init = 1'b0;

    // 5: modulo wrap
    do_reset();
    branch(JM_ABS, 1'b0, 0, 1020);
    branch(JM_REL, 1'b1, 8, 0);
    check("wrap_fwd", bus.PC, 4);
    branch(JM_ABS, 1'b0, 0, 3);
    branch(JM_REL, 1'b0, 5, 0);
    check("wrap_back", bus.PC, 1022);
    branch(JM_REL, 1'b1, 0, 0);
    check("self_loop", bus.PC, 1022);
    step();
    step();
    check("wrap_inc", bus.PC, 0);

    // 6a: halt match beats a call in the same cycle
    do_reset();
    bus.HaltAddrs[0 +: 10] = 10'd0;
    bus.HaltMask = 3'b001;
    branch(JM_CALL, 1'b0, 0, 100);
    check("hcall_pc", bus.PC, 1);
    check("hcall_halt", bus.halt, 1);
    check("hcall_depth", bus.StackDepth, 0);

    // 6b: stall suppresses halt evaluation; async reset while halted
    do_reset();
    bus.HaltAddrs[20 +: 10] = 10'd29;
    bus.HaltMask = 3'b100;
    branch(JM_ABS, 1'b0, 0, 29);
    bus.Stall = 1'b1;
    step(3);
    check("stall_pc", bus.PC, 29);
    check("stall_halt", bus.halt, 0);
    bus.Stall = 1'b0;
    step();
    check("rel_pc", bus.PC, 30);
    check("rel_halt", bus.halt, 1);
    init = 1'b1;
    #1;
    check("async_pc", bus.PC, 0);
    check("async_halt", bus.halt, 0);
    check("async_err2", bus.StackErr, 0);
    init = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised program counter and sequencer for the single-cycle core.
- Successor to the fixed-width PC:
  - relative branches with a configurable offset width;
  - absolute jumps;
  - call/return through an internal return-address stack;
  - a programmable halt-address table (runtime inputs) in place of hard-coded halt PCs;
  - stall and resume control.
- Drives instruction-memory address; the decoder supplies branch/jump controls.

Parameters:
- PC_W, 10, PC and address width.
- OFF_W, 8, relative jump magnitude width.
- NUM_HALT, 3, number of halt-address comparators.
- RAS_DEPTH, 4, return-address stack entries (≥1).
- RESET_PC, 0, PC value after reset.

Ports:
- CLK  in  1  clock, rising edge.
- init  in  1  reset, asynchronous, active-high.
- Stall  in  1  hold PC this cycle (no state change except Resume handling).
- BranchEnable  in  1  current instruction is a control-flow instruction.
- BranchTaken  in  1  condition true; unconditional ops assert it.
- JumpMode  in  2  0=relative, 1=absolute, 2=call (absolute), 3=return.
- JumpDirection  in  1  relative only: 1=forward (+), 0=backward (−).
- JumpAmount  in  OFF_W  relative magnitude, unsigned.
- JumpTarget  in  PC_W  absolute/call target.
- HaltAddrs  in  NUM_HALT*PC_W  packed halt addresses; entry i at bits [i*PC_W +: PC_W].
- HaltMask  in  NUM_HALT  per-entry enable.
- Resume  in  1  clears halt.
- PC  out  PC_W  current PC (registered).
- halt  out  1  core halted.
- StackErr  out  1  sticky; set on RAS overflow or underflow.
- StackDepth  out  $clog2(RAS_DEPTH+1)  valid RAS entries.

Behaviour:
- Reset (init=1, async):
  - PC=RESET_PC, halt=0, StackErr=0, StackDepth=0.
  - RAS contents don't-care.
- Advancing cycle = !init && !halt && !Stall. Only advancing cycles change PC or the RAS.
- Halt match has highest priority:
  - Condition: any i with HaltMask[i] && HaltAddrs[i]==PC.
  - Action: PC<=PC+1, halt<=1, branch/call/return ignored, RAS untouched.
- Otherwise, if BranchEnable && BranchTaken, by JumpMode:
  - 0: PC <= PC ± zero-extended JumpAmount.
  - 1: PC <= JumpTarget.
  - 2: if StackDepth<RAS_DEPTH, push PC+1 and PC<=JumpTarget. Else overflow: no push, PC holds, StackErr<=1, halt<=1.
  - 3: if StackDepth>0, PC<=top and pop. Else underflow: PC holds, StackErr<=1, halt<=1.
- Otherwise: PC<=PC+1.
- Arithmetic: all PC math is modulo 2^PC_W.
  - Forward overflow wraps: max PC + 1 → 0.
  - Backward underflow wraps: 0 − 1 → 2^PC_W−1.
  - JumpAmount=0 relative: PC holds (a legal self-loop).
- Halted:
  - PC, RAS and StackErr hold.
  - Resume=1 at an edge → halt<=0, PC unchanged; execution continues next cycle.
  - No re-trigger, since PC already moved past the halt address.
  - Resume is ignored when not halted.
  - Resume does not clear StackErr; only init clears it.
- Stall=1 while running: everything holds; halt comparators are not evaluated that cycle.
- Simultaneous:
  - Halt match + call in the same cycle: halt wins, no push.
  - Push at exactly RAS_DEPTH−1 entries succeeds (depth becomes full).
- Reset mid-operation, including while halted or mid-stall, immediately forces reset values.
- Single state bit: RUN (halt=0) / HALTED (halt=1).
  - RUN→HALTED on halt match or stack error.
  - HALTED→RUN on Resume.

Decomposition:
- Package pc_seq_pkg:
  - typedef jump_mode_e {JM_REL, JM_ABS, JM_CALL, JM_RET};
  - RAS depth/pointer width helper.
- One sub-module: pc_ras (LIFO, push/pop/full/empty/top, async-reset pointer).
- Halt comparators and next-PC mux stay in pc_seq.

Test Plan:
1. Reset → PC=0, halt=0. Advance 5 cycles → PC=5. Relative +20 at PC=5 → 25; −10 at PC=25 → 15.
2. HaltAddrs[0]=30, mask=001, run sequentially → PC=31, halt=1 and holding 4 cycles. Resume pulse → halt=0, next cycle PC=32.
3. Call JumpTarget=100 at PC=7 → PC=100, StackDepth=1. Return at PC=104 → PC=8, StackDepth=0.
4. RAS_DEPTH=4: nested calls.
   - 4 calls succeed (depth 4).
   - 5th call → PC holds, StackErr=1, halt=1.
   - Separate run: return with empty stack → PC holds, StackErr=1, halt=1.
5. PC_W=10: PC=1020, relative +8 → PC=4. PC=3, relative −5 → PC=1022.
6. Stall=1 for 3 cycles at PC=29 with halt addr 29 enabled → PC stays 29, halt=0. Release → PC=30, halt=1. Assert init mid-halt → PC=0, halt=0, StackErr=0 asynchronously.
